// File: rtl/keypad_digit_entry.sv
// Keypad scanner with debounce, digit entry register and 7-seg drive.
// Scans a 4x4 active-low matrix; accepted keys edit a NUM_DIGITS nibble register.
module keypad_digit_entry #(
  parameter int unsigned TICK_DIV       = 500000,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter bit          HEX_MODE       = 1'b0,
  parameter logic [3:0]  CODE_BS        = 4'hE,
  parameter logic [3:0]  CODE_CLR       = 4'hF
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [3:0]              ROW,
  output logic [3:0]              COL,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              digits,
  output logic                    full,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned HW = 7 * NUM_DIGITS;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  logic [3:0]    row_s1_q;
  logic [3:0]    row_s2_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  state_e        state_q;
  logic [3:0]    col_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  logic          row_idle;
  logic          row_one;
  logic [1:0]    row_idx;

  logic [VW-1:0] value_q;
  logic [VW-1:0] value_d;
  logic [3:0]    digits_q;
  logic [3:0]    digits_d;
  logic          full_q;
  logic          is_digit;
  logic [HW-1:0] hex_q;
  logic [HW-1:0] hex_d;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= ROW;
      row_s2_q <= row_s1_q;
    end
  end

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Only a single low row is a real key; multi-row patterns are ghosts.
  always_comb begin
    row_idle = (row_s2_q == 4'hF);
    row_one  = 1'b1;
    row_idx  = 2'd0;
    case (row_s2_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_one = 1'b0;
    endcase
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= SCAN;
      col_q       <= 4'b1110;
      col_idx_q   <= 2'd0;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (row_one) begin
              cand_q <= {row_idx, col_idx_q};
              cnt_q  <= CW'(1);
              if (DEBOUNCE_TICKS == 1) begin
                key_code_q  <= {row_idx, col_idx_q};
                key_valid_q <= 1'b1;
                state_q     <= HELD;
              end else begin
                state_q <= DEBOUNCE;
              end
            end else begin
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (row_one && row_idx == cand_q[3:2]) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                state_q     <= HELD;
              end
            end else begin
              state_q   <= SCAN;
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          HELD: begin
            if (row_idle) begin
              cnt_q <= CW'(1);
              if (DEBOUNCE_TICKS == 1) begin
                state_q   <= SCAN;
                col_q     <= {col_q[2:0], col_q[3]};
                col_idx_q <= col_idx_q + 2'd1;
              end else begin
                state_q <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (row_idle) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                state_q   <= SCAN;
                col_q     <= {col_q[2:0], col_q[3]};
                col_idx_q <= col_idx_q + 2'd1;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  always_comb begin
    is_digit = HEX_MODE ? 1'b1 : (key_code_q <= 4'd9);
    value_d  = value_q;
    digits_d = digits_q;
    if (key_valid_q) begin
      if (key_code_q == CODE_CLR) begin
        value_d  = '0;
        digits_d = 4'd0;
      end else if (key_code_q == CODE_BS) begin
        if (digits_q != 4'd0) begin
          value_d  = value_q >> 4;
          digits_d = digits_q - 4'd1;
        end
      end else if (is_digit && !full_q) begin
        value_d  = (value_q << 4) | VW'(key_code_q);
        digits_d = digits_q + 4'd1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  always_comb begin
    hex_d = '1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (4'(k) < digits_q) begin
        hex_d[7*k +: 7] = seg7(value_q[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      value_q  <= '0;
      digits_q <= 4'd0;
      full_q   <= 1'b0;
      hex_q    <= '1;
    end else begin
      value_q  <= value_d;
      digits_q <= digits_d;
      full_q   <= (digits_d == 4'(NUM_DIGITS));
      hex_q    <= hex_d;
    end
  end

  assign COL       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign value     = value_q;
  assign digits    = digits_q;
  assign full      = full_q;
  assign HEX       = hex_q;

endmodule
